// File: rtl/matvec_pkg.sv
// Shared types and sizes for the matrix-vector multiplier controller and datapath.
package matvec_pkg;

  localparam int MV_S     = 8;
  localparam int MV_IN_W  = 14;
  localparam int MV_OUT_W = 28;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_X  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_OUTPUT  = 3'd4
  } mv_state_t;

endpackage

// File: rtl/matvec_seq_ctrl_counter.sv
// Wrapping up-counter with clear (priority) and increment; last flags the terminal value.
module mv_up_counter
  import matvec_pkg::*;
#(
  parameter int W    = 4,
  parameter int TERM = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         incr,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (cnt == W'(TERM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (incr) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/matvec_seq_ctrl.sv
// Steers the input stream into weight/vector memories, waits out the datapath
// pipeline, then presents S row results over a valid/ready handshake.
module matvec_seq_ctrl
  import matvec_pkg::*;
#(
  parameter int S        = MV_S,
  parameter int PIPE_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic                 new_matrix,
  output logic [S*S-1:0]       wr_en_w,
  output logic [S-1:0]         wr_en_x,
  output logic                 compute_start,
  output logic [$clog2(S)-1:0] out_sel,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic                 job_done,
  output logic                 w_loaded
);

  localparam int WC_W  = $clog2(S*S);
  localparam int XC_W  = $clog2(S);
  localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [S*S-1:0] W_ONE = {{(S*S-1){1'b0}}, 1'b1};
  localparam logic [S-1:0]   X_ONE = {{(S-1){1'b0}}, 1'b1};

  mv_state_t        state_q, state_d;
  logic             xfer, load_w_path;
  logic             w_inc, w_clr, x_inc, x_clr, lat_clr, out_inc, out_clr;
  logic             w_last, x_last, lat_last, out_last;
  logic [WC_W-1:0]  w_cnt;
  logic [XC_W-1:0]  x_cnt;
  logic [LAT_W-1:0] lat_cnt;

  assign input_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD_W) ||
                       (state_q == ST_LOAD_X);
  assign xfer        = input_valid & input_ready;
  // Weights are reloaded whenever none are resident, regardless of new_matrix.
  assign load_w_path = new_matrix | ~w_loaded;

  // Counters sit at zero outside their own phase; the IDLE transfer counts word 0.
  assign w_inc   = xfer & ((state_q == ST_LOAD_W) | ((state_q == ST_IDLE) & load_w_path));
  assign w_clr   = (state_q != ST_LOAD_W) & ~w_inc;
  assign x_inc   = xfer & ((state_q == ST_LOAD_X) | ((state_q == ST_IDLE) & ~load_w_path));
  assign x_clr   = (state_q != ST_LOAD_X) & ~x_inc;
  assign lat_clr = (state_q != ST_COMPUTE);
  assign out_inc = (state_q == ST_OUTPUT) & output_ready;
  assign out_clr = (state_q != ST_OUTPUT);

  mv_up_counter #(.W(WC_W), .TERM(S*S-1)) u_w_cnt (
    .clk(clk), .reset(reset), .clr(w_clr), .incr(w_inc), .cnt(w_cnt), .last(w_last)
  );

  mv_up_counter #(.W(XC_W), .TERM(S-1)) u_x_cnt (
    .clk(clk), .reset(reset), .clr(x_clr), .incr(x_inc), .cnt(x_cnt), .last(x_last)
  );

  mv_up_counter #(.W(LAT_W), .TERM(PIPE_LAT-1)) u_lat_cnt (
    .clk(clk), .reset(reset), .clr(lat_clr), .incr(~lat_clr), .cnt(lat_cnt),
    .last(lat_last)
  );

  mv_up_counter #(.W(XC_W), .TERM(S-1)) u_out_sel (
    .clk(clk), .reset(reset), .clr(out_clr), .incr(out_inc), .cnt(out_sel),
    .last(out_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_loaded <= 1'b0;
    end else if (xfer && (state_q == ST_IDLE) && load_w_path) begin
      w_loaded <= 1'b0;
    end else if (xfer && (state_q == ST_LOAD_W) && w_last) begin
      w_loaded <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (xfer) state_d = load_w_path ? ST_LOAD_W : ST_LOAD_X;
      ST_LOAD_W:  if (xfer && w_last) state_d = ST_LOAD_X;
      ST_LOAD_X:  if (xfer && x_last) state_d = ST_COMPUTE;
      ST_COMPUTE: if (lat_last) state_d = ST_OUTPUT;
      ST_OUTPUT:  if (output_ready && out_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en_w       = '0;
    wr_en_x       = '0;
    compute_start = 1'b0;
    output_valid  = 1'b0;
    job_done      = 1'b0;
    if (w_inc) wr_en_w = W_ONE << w_cnt;
    if (x_inc) wr_en_x = X_ONE << x_cnt;
    if (state_q == ST_COMPUTE) compute_start = (lat_cnt == '0);
    if (state_q == ST_OUTPUT) begin
      output_valid = 1'b1;
      job_done     = output_ready & out_last;
    end
  end

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// Scoreboard bench: expected write-enable and output-transfer sequences are queued per job.
module tb_matvec_seq_ctrl;

  localparam int S        = 8;
  localparam int PIPE_LAT = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 input_valid = 1'b0;
  logic                 input_ready;
  logic                 new_matrix = 1'b0;
  logic [S*S-1:0]       wr_en_w;
  logic [S-1:0]         wr_en_x;
  logic                 compute_start;
  logic [$clog2(S)-1:0] out_sel;
  logic                 output_valid;
  logic                 output_ready = 1'b1;
  logic                 job_done;
  logic                 w_loaded;

  int n_vec = 0;
  int n_err = 0;
  int exp_wr[$];
  int exp_out[$];
  bit mdl_wl = 1'b0;

  matvec_seq_ctrl #(.S(S), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready), .new_matrix(new_matrix),
    .wr_en_w(wr_en_w), .wr_en_x(wr_en_x), .compute_start(compute_start),
    .out_sel(out_sel), .output_valid(output_valid), .output_ready(output_ready),
    .job_done(job_done), .w_loaded(w_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Writes encode as index (weights) or 1000+index (vector); outputs as out_sel*2+job_done.
  always @(negedge clk) begin : mon
    int hot;
    int code;
    if (reset) begin
      hot  = 0;
      code = -1;
      for (int i = 0; i < S*S; i++) if (wr_en_w[i]) begin hot++; code = i; end
      for (int i = 0; i < S; i++)   if (wr_en_x[i]) begin hot++; code = 1000 + i; end
      if (hot > 1) chk("wr_onehot", hot, 1);
      if (hot != 0 && !(input_valid && input_ready)) chk("wr_without_xfer", hot, 0);
      if (hot == 0 && input_valid && input_ready) chk("wr_missing", hot, 1);
      if (hot == 1) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", code, -1);
        else chk("wr_order", code, exp_wr.pop_front());
      end
      if (output_valid && output_ready) begin
        if (exp_out.size() == 0) chk("out_unexpected", out_sel * 2 + job_done, -1);
        else chk("out_xfer", out_sel * 2 + job_done, exp_out.pop_front());
      end
      if (job_done && !(output_valid && output_ready)) chk("done_without_xfer", job_done, 0);
    end
  end

  // Leaves reset asserted briefly, checks reset values, releases at posedge+1.
  task automatic do_reset();
    input_valid = 1'b0;
    new_matrix  = 1'b0;
    reset       = 1'b0;
    mdl_wl      = 1'b0;
    #1;
    chk("rst_in_rdy", input_ready, 1);
    chk("rst_wr_w", int'(wr_en_w != '0), 0);
    chk("rst_wr_x", int'(wr_en_x), 0);
    chk("rst_cstart", compute_start, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_vld", output_valid, 0);
    chk("rst_done", job_done, 0);
    chk("rst_wl", w_loaded, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Entry and exit at posedge+1. stop_after >= 0 truncates the load.
  task automatic load_job(input bit nm, input bit full, input bit gap, input int stop_after);
    int n;
    n = full ? S*S + S : S;
    for (int k = 0; k < n; k++) begin
      if (k == stop_after) return;
      if (gap && k > 0) begin
        input_valid = 1'b0;
        new_matrix  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      input_valid = 1'b1;
      new_matrix  = (k == 0) ? nm : 1'($urandom_range(0, 1));
      exp_wr.push_back((full && k < S*S) ? k : 1000 + (full ? k - S*S : k));
      @(negedge clk);
      chk("load_in_rdy", input_ready, 1);
      @(posedge clk);
      #1;
      if (k == 0) chk("wl_after_first", w_loaded, full ? 0 : 1);
    end
    input_valid = 1'b0;
    new_matrix  = 1'b0;
  endtask

  task automatic post_load_check();
    for (int c = 1; c <= PIPE_LAT + 1; c++) begin
      @(negedge clk);
      chk("compute_start", compute_start, int'(c == 1));
      chk("out_vld_rise", output_valid, int'(c == PIPE_LAT + 1));
      chk("in_rdy_busy", input_ready, 0);
    end
  endtask

  task automatic drain(input int stall_at, input int stall_len);
    for (int r = 0; r < S; r++) begin
      if (r > 0) @(negedge clk);
      chk("out_sel", out_sel, r);
      chk("out_vld", output_valid, 1);
      chk("job_done", job_done, int'(r == S - 1));
      if (r + 1 == stall_at) begin
        @(posedge clk);
        #1;
        output_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          chk("stall_sel", out_sel, stall_at);
          chk("stall_vld", output_valid, 1);
          chk("stall_done", job_done, 0);
        end
        @(posedge clk);
        #1;
        output_ready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("idle_in_rdy", input_ready, 1);
    chk("idle_out_vld", output_valid, 0);
  endtask

  task automatic run_job(input bit nm, input bit gap, input int stall_at, input int stall_len);
    bit full;
    full = nm || !mdl_wl;
    for (int r = 0; r < S; r++) exp_out.push_back(r * 2 + int'(r == S - 1));
    load_job(nm, full, gap, -1);
    mdl_wl = 1'b1;
    post_load_check();
    drain(stall_at, stall_len);
    chk("wl_end", w_loaded, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    do_reset();
    run_job(1'b1, 1'b0, -1, 0);
    run_job(1'b0, 1'b0, -1, 0);
    do_reset();
    run_job(1'b0, 1'b0, -1, 0);
    run_job(1'b1, 1'b1, 3, 5);
    load_job(1'b1, 1'b1, 1'b0, 20);
    chk("partial_drained", exp_wr.size(), 0);
    chk("partial_wl", w_loaded, 0);
    do_reset();
    run_job(1'b0, 1'b0, -1, 0);
    run_job(1'b0, 1'b1, -1, 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("out_queue_empty", exp_out.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
